// File: rtl/tt_vga_pkg.sv
// Shared definitions for the Tiny VGA PMOD receiver: bus bit positions,
// RGB222 packing order and the default counter width.
package tt_vga_pkg;

    localparam int CW_DEFAULT = 11;

    // Bit positions of the Tiny VGA PMOD bus as driven on uo_out[7:0]
    localparam int PMOD_R1    = 0;
    localparam int PMOD_G1    = 1;
    localparam int PMOD_B1    = 2;
    localparam int PMOD_VSYNC = 3;
    localparam int PMOD_R0    = 4;
    localparam int PMOD_G0    = 5;
    localparam int PMOD_B0    = 6;
    localparam int PMOD_HSYNC = 7;

    // Pixel colour as presented downstream, MSB first: {R1,R0,G1,G0,B1,B0}
    typedef struct packed {
        logic r1;
        logic r0;
        logic g1;
        logic g0;
        logic b1;
        logic b0;
    } rgb222_t;

    // Regroup the interleaved PMOD colour bits into per-channel pairs
    function automatic rgb222_t pmod_to_rgb(input logic [7:0] bus);
        rgb222_t c;
        c.r1 = bus[PMOD_R1];
        c.r0 = bus[PMOD_R0];
        c.g1 = bus[PMOD_G1];
        c.g0 = bus[PMOD_G0];
        c.b1 = bus[PMOD_B1];
        c.b0 = bus[PMOD_B0];
        return c;
    endfunction

endpackage

// File: rtl/tt_vga_sync_axis.sv
// One timing axis of the receiver (used once for lines, once for frames):
// leading-edge detector, saturating position counter, period latch and an
// "equal twice in a row" stability indication.
module tt_vga_sync_axis
    import tt_vga_pkg::*;
#(
    parameter int   CW  = CW_DEFAULT,
    parameter logic POL = 1'b0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic          sync,
    input  logic          step,
    output logic          sync_edge,
    output logic [CW-1:0] pos,
    output logic          sat_first,
    output logic          latch,
    output logic          stable_next,
    output logic [CW-1:0] period
);

    localparam logic [CW-1:0] POS_MAX = '1;

    logic          prev_sync;
    logic [CW-1:0] pos_q;
    logic          seen_edge;
    logic          have_period;
    logic          stable_q;
    logic [CW-1:0] period_new;

    // Position of the sample being taken now, plus edge/latch/stability decisions
    always_comb begin
        sync_edge   = en && (sync == POL) && (prev_sync != POL);
        pos         = pos_q;
        sat_first   = 1'b0;
        if (sync_edge) begin
            pos = '0;
        end else if (step) begin
            if (pos_q != POS_MAX) begin
                pos = pos_q + 1'b1;
            end
            sat_first = (pos_q == POS_MAX - 1'b1);
        end
        period_new  = (pos_q == POS_MAX) ? POS_MAX : pos_q + 1'b1;
        latch       = sync_edge && seen_edge;
        stable_next = latch ? (have_period && (period_new == period)) : stable_q;
    end

    // Axis state only moves on pixel strobes; the period is captured from the second edge on
    always_ff @(posedge clk) begin
        if (rst) begin
            prev_sync   <= ~POL;
            pos_q       <= '0;
            seen_edge   <= 1'b0;
            have_period <= 1'b0;
            stable_q    <= 1'b0;
            period      <= '0;
        end else if (en) begin
            prev_sync <= sync;
            pos_q     <= pos;
            stable_q  <= stable_next;
            if (sync_edge) begin
                seen_edge <= 1'b1;
            end
            if (latch) begin
                period      <= period_new;
                have_period <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/tt_vga_pmod_rx.sv
// Receive side of the Tiny VGA PMOD bus: recovers sync timing, emits the
// active-region pixel stream with coordinates and measures line/frame size.
module tt_vga_pmod_rx
    import tt_vga_pkg::*;
#(
    parameter int   CW        = CW_DEFAULT,
    parameter int   H_SYNC    = 96,
    parameter int   H_BP      = 48,
    parameter int   H_ACTIVE  = 640,
    parameter int   V_SYNC    = 2,
    parameter int   V_BP      = 33,
    parameter int   V_ACTIVE  = 480,
    parameter logic HSYNC_POL = 1'b0,
    parameter logic VSYNC_POL = 1'b0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          pix_en,
    input  logic [7:0]    pmod_in,
    output logic          pix_valid,
    output logic [CW-1:0] pix_x,
    output logic [CW-1:0] pix_y,
    output logic [5:0]    pix_rgb,
    output logic          frame_start,
    output logic [CW-1:0] line_len,
    output logic [CW-1:0] frame_lines,
    output logic          locked,
    output logic          sync_err
);

    localparam logic [CW-1:0] H_START = CW'(H_SYNC + H_BP);
    localparam logic [CW-1:0] H_END   = CW'(H_SYNC + H_BP + H_ACTIVE);
    localparam logic [CW-1:0] V_START = CW'(V_SYNC + V_BP);
    localparam logic [CW-1:0] V_END   = CW'(V_SYNC + V_BP + V_ACTIVE);

    logic          h_edge;
    logic [CW-1:0] h_pos;
    logic          h_sat;
    logic          h_latch;
    logic          h_stable_next;
    logic          v_edge;
    logic [CW-1:0] v_pos;
    logic          v_sat;
    logic          v_latch;
    logic          v_stable_next;
    logic          in_window;
    logic [CW-1:0] x_next;
    logic [CW-1:0] y_next;
    logic          unused_v;

    tt_vga_sync_axis #(
        .CW  (CW),
        .POL (HSYNC_POL)
    ) u_h_axis (
        .clk         (clk),
        .rst         (rst),
        .en          (pix_en),
        .sync        (pmod_in[PMOD_HSYNC]),
        .step        (pix_en),
        .sync_edge   (h_edge),
        .pos         (h_pos),
        .sat_first   (h_sat),
        .latch       (h_latch),
        .stable_next (h_stable_next),
        .period      (line_len)
    );

    tt_vga_sync_axis #(
        .CW  (CW),
        .POL (VSYNC_POL)
    ) u_v_axis (
        .clk         (clk),
        .rst         (rst),
        .en          (pix_en),
        .sync        (pmod_in[PMOD_VSYNC]),
        .step        (h_edge),
        .sync_edge   (v_edge),
        .pos         (v_pos),
        .sat_first   (v_sat),
        .latch       (v_latch),
        .stable_next (v_stable_next),
        .period      (frame_lines)
    );

    // The vertical edge only drives the counter inside the axis, and a missing
    // vsync is not reported as an error, so these two are intentionally dropped.
    assign unused_v = v_edge ^ v_sat;

    // Active-window test and region-relative coordinates for the current sample
    always_comb begin
        in_window = pix_en &&
                    (h_pos >= H_START) && (h_pos < H_END) &&
                    (v_pos >= V_START) && (v_pos < V_END);
        x_next    = h_pos - H_START;
        y_next    = v_pos - V_START;
    end

    // Output registers: pulses drop when idle, pixel data and lock state hold
    always_ff @(posedge clk) begin
        if (rst) begin
            pix_valid   <= 1'b0;
            pix_x       <= '0;
            pix_y       <= '0;
            pix_rgb     <= '0;
            frame_start <= 1'b0;
            sync_err    <= 1'b0;
            locked      <= 1'b0;
        end else begin
            pix_valid   <= in_window;
            frame_start <= in_window && (x_next == '0) && (y_next == '0);
            sync_err    <= h_sat;
            if (in_window) begin
                pix_x   <= x_next;
                pix_y   <= y_next;
                pix_rgb <= pmod_to_rgb(pmod_in);
            end
            if (h_sat) begin
                locked <= 1'b0;
            end else if (h_latch || v_latch) begin
                locked <= h_stable_next && v_stable_next;
            end
        end
    end

endmodule

// File: tb/tb_tt_vga_pmod_rx.sv
// Self-checking bench for tt_vga_pmod_rx using a reduced video timing,
// random colours and strobe gaps, and a line/frame-level reference model.
module tb_tt_vga_pmod_rx;

    localparam int   CW       = 11;
    localparam int   H_SYNC   = 2;
    localparam int   H_BP     = 2;
    localparam int   H_ACTIVE = 8;
    localparam int   V_SYNC   = 1;
    localparam int   V_BP     = 1;
    localparam int   V_ACTIVE = 4;
    localparam logic HPOL     = 1'b0;
    localparam logic VPOL     = 1'b0;
    localparam int   LINE     = 14;
    localparam int   FRAME    = 7;
    localparam int   HMAX     = (1 << CW) - 1;

    logic          clk;
    logic          rst;
    logic          pix_en;
    logic [7:0]    pmod_in;
    logic          pix_valid;
    logic [CW-1:0] pix_x;
    logic [CW-1:0] pix_y;
    logic [5:0]    pix_rgb;
    logic          frame_start;
    logic [CW-1:0] line_len;
    logic [CW-1:0] frame_lines;
    logic          locked;
    logic          sync_err;

    int n_compared;
    int n_mismatched;

    // Reference model state: sync history, positions and every latched measurement
    bit m_hs_prev;
    bit m_vs_prev;
    int m_hpos;
    int m_vpos;
    int m_h_edges;
    int m_v_edges;
    int hist_h[$];
    int hist_v[$];
    bit m_locked;
    bit e_valid;
    bit e_fs;
    bit e_err;
    int e_x;
    int e_y;
    int e_rgb;
    int e_len;
    int e_lines;

    // Monitors for directed checks
    int valid_count;
    int sof_count;
    int err_count;
    bit saw_unlock;
    bit saw_len13;

    tt_vga_pmod_rx #(
        .CW        (CW),
        .H_SYNC    (H_SYNC),
        .H_BP      (H_BP),
        .H_ACTIVE  (H_ACTIVE),
        .V_SYNC    (V_SYNC),
        .V_BP      (V_BP),
        .V_ACTIVE  (V_ACTIVE),
        .HSYNC_POL (HPOL),
        .VSYNC_POL (VPOL)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .pix_en      (pix_en),
        .pmod_in     (pmod_in),
        .pix_valid   (pix_valid),
        .pix_x       (pix_x),
        .pix_y       (pix_y),
        .pix_rgb     (pix_rgb),
        .frame_start (frame_start),
        .line_len    (line_len),
        .frame_lines (frame_lines),
        .locked      (locked),
        .sync_err    (sync_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: got timeout, want completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_compared++;
        if (observed !== expected) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got %0d, want %0d (t=%0t)", tag, observed, expected, $time);
        end
    endtask

    function automatic bit settled_h();
        return (hist_h.size() >= 2) && (hist_h[$] == hist_h[$-1]);
    endfunction

    function automatic bit settled_v();
        return (hist_v.size() >= 2) && (hist_v[$] == hist_v[$-1]);
    endfunction

    task automatic model_reset();
        m_hs_prev = 1'b0;
        m_vs_prev = 1'b0;
        m_hpos    = 0;
        m_vpos    = 0;
        m_h_edges = 0;
        m_v_edges = 0;
        hist_h.delete();
        hist_v.delete();
        m_locked  = 1'b0;
        e_valid   = 1'b0;
        e_fs      = 1'b0;
        e_err     = 1'b0;
        e_x       = 0;
        e_y       = 0;
        e_rgb     = 0;
        e_len     = 0;
        e_lines   = 0;
    endtask

    // Apply the receiver rules to one strobed sample
    task automatic model_pixel(input logic [7:0] bus);
        bit hs;
        bit vs;
        bit he;
        bit ve;
        bit new_latch;
        hs = (bus[7] == HPOL);
        vs = (bus[3] == VPOL);
        he = hs && !m_hs_prev;
        ve = vs && !m_vs_prev;
        m_hs_prev = hs;
        m_vs_prev = vs;
        e_err = 1'b0;
        e_fs  = 1'b0;
        new_latch = 1'b0;
        if (he) begin
            m_h_edges++;
            if (m_h_edges >= 2) begin
                hist_h.push_back((m_hpos + 1 > HMAX) ? HMAX : m_hpos + 1);
                e_len = hist_h[$];
                new_latch = 1'b1;
            end
            m_hpos = 0;
        end else if (m_hpos < HMAX) begin
            m_hpos++;
            if (m_hpos == HMAX) e_err = 1'b1;
        end
        if (ve) begin
            m_v_edges++;
            if (m_v_edges >= 2) begin
                hist_v.push_back((m_vpos + 1 > HMAX) ? HMAX : m_vpos + 1);
                e_lines = hist_v[$];
                new_latch = 1'b1;
            end
            m_vpos = 0;
        end else if (he && m_vpos < HMAX) begin
            m_vpos++;
        end
        if (e_err) m_locked = 1'b0;
        else if (new_latch) m_locked = settled_h() && settled_v();
        e_valid = (m_hpos >= H_SYNC + H_BP) && (m_hpos < H_SYNC + H_BP + H_ACTIVE) &&
                  (m_vpos >= V_SYNC + V_BP) && (m_vpos < V_SYNC + V_BP + V_ACTIVE);
        if (e_valid) begin
            e_x   = m_hpos - (H_SYNC + H_BP);
            e_y   = m_vpos - (V_SYNC + V_BP);
            e_rgb = 32'({bus[0], bus[4], bus[1], bus[5], bus[2], bus[6]});
            e_fs  = (e_x == 0) && (e_y == 0);
        end
    endtask

    // Drive one cycle, advance the model and compare every output
    task automatic applyStimulus(input logic en, input logic [7:0] bus);
        pix_en  = en;
        pmod_in = bus;
        @(posedge clk);
        #1;
        if (en) begin
            model_pixel(bus);
        end else begin
            e_valid = 1'b0;
            e_fs    = 1'b0;
            e_err   = 1'b0;
        end
        checkOutput("pix_valid", 32'(pix_valid), 32'(e_valid));
        checkOutput("frame_start", 32'(frame_start), 32'(e_fs));
        checkOutput("sync_err", 32'(sync_err), 32'(e_err));
        checkOutput("line_len", 32'(line_len), e_len);
        checkOutput("frame_lines", 32'(frame_lines), e_lines);
        checkOutput("locked", 32'(locked), 32'(m_locked));
        if (e_valid) begin
            checkOutput("pix_x", 32'(pix_x), e_x);
            checkOutput("pix_y", 32'(pix_y), e_y);
            checkOutput("pix_rgb", 32'(pix_rgb), e_rgb);
        end
        valid_count += int'(pix_valid);
        sof_count   += int'(frame_start);
        err_count   += int'(sync_err);
        if (!locked) saw_unlock = 1'b1;
        if (32'(line_len) == 13) saw_len13 = 1'b1;
    endtask

    task automatic applyReset();
        rst     = 1'b1;
        pix_en  = 1'b0;
        pmod_in = 8'($urandom);
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_valid", 32'(pix_valid), 0);
        checkOutput("rst_sof", 32'(frame_start), 0);
        checkOutput("rst_x", 32'(pix_x), 0);
        checkOutput("rst_y", 32'(pix_y), 0);
        checkOutput("rst_rgb", 32'(pix_rgb), 0);
        checkOutput("rst_len", 32'(line_len), 0);
        checkOutput("rst_lines", 32'(frame_lines), 0);
        checkOutput("rst_locked", 32'(locked), 0);
        checkOutput("rst_err", 32'(sync_err), 0);
        rst = 1'b0;
        model_reset();
    endtask

    // Idle gap cycles with junk on the bus, then one strobed pixel
    task automatic send_pixel(input bit hs, input bit vs, input int gap, input bit mark);
        logic [7:0] bus;
        for (int g = 0; g < gap; g++) applyStimulus(1'b0, 8'($urandom));
        bus = 8'($urandom);
        if (mark) begin
            bus[6:4] = 3'b101;
            bus[2:0] = 3'b010;
        end
        bus[7] = hs ? HPOL : ~HPOL;
        bus[3] = vs ? VPOL : ~VPOL;
        applyStimulus(1'b1, bus);
        if (mark) begin
            checkOutput("ex_valid", 32'(pix_valid), 1);
            checkOutput("ex_x", 32'(pix_x), 3);
            checkOutput("ex_y", 32'(pix_y), 1);
            checkOutput("ex_rgb", 32'(pix_rgb), 32'b011001);
        end
    endtask

    // gap_mode: 0 = strobe every cycle, 1 = every 3rd cycle, 2 = random gaps
    task automatic gen_frame(input int gap_mode, input int short_line, input int first_line,
                             input int first_col, input bit mark);
        for (int ln = first_line; ln < FRAME; ln++) begin
            int len;
            len = (ln == short_line) ? LINE - 1 : LINE;
            for (int col = (ln == first_line) ? first_col : 0; col < len; col++) begin
                int gap;
                gap = (gap_mode == 0) ? 0 : (gap_mode == 1) ? 2 : int'($urandom_range(0, 2));
                send_pixel(col < H_SYNC, ln < V_SYNC, gap,
                           mark && (ln == V_SYNC + V_BP + 1) && (col == H_SYNC + H_BP + 3));
            end
        end
    endtask

    initial begin
        n_compared   = 0;
        n_mismatched = 0;
        valid_count  = 0;
        sof_count    = 0;
        err_count    = 0;
        saw_unlock   = 1'b0;
        saw_len13    = 1'b0;
        rst          = 1'b1;
        pix_en       = 1'b0;
        pmod_in      = 8'h00;
        model_reset();
        applyReset();

        $display("[TB] continuous strobe, three frames");
        gen_frame(0, -1, 0, 0, 1'b0);
        valid_count = 0;
        sof_count   = 0;
        gen_frame(0, -1, 0, 0, 1'b0);
        checkOutput("valid_per_frame", 32'(valid_count), 32);
        checkOutput("sof_per_frame", 32'(sof_count), 1);
        gen_frame(0, -1, 0, 0, 1'b0);
        checkOutput("locked_after_frames", 32'(locked), 1);
        checkOutput("line_len_nominal", 32'(line_len), 14);
        checkOutput("frame_lines_nominal", 32'(frame_lines), 7);

        $display("[TB] strobe every third cycle");
        valid_count = 0;
        sof_count   = 0;
        gen_frame(1, -1, 0, 0, 1'b0);
        checkOutput("valid_per_frame_slow", 32'(valid_count), 32);
        checkOutput("sof_per_frame_slow", 32'(sof_count), 1);
        gen_frame(1, -1, 0, 0, 1'b0);

        $display("[TB] colour remap example");
        gen_frame(0, -1, 0, 0, 1'b1);

        $display("[TB] shortened line");
        saw_unlock = 1'b0;
        saw_len13  = 1'b0;
        gen_frame(0, 3, 0, 0, 1'b0);
        checkOutput("short_len_seen", 32'(saw_len13), 1);
        checkOutput("short_unlock_seen", 32'(saw_unlock), 1);
        checkOutput("short_relock", 32'(locked), 1);
        checkOutput("short_len_back", 32'(line_len), 14);

        $display("[TB] random strobe gaps");
        gen_frame(2, -1, 0, 0, 1'b0);
        gen_frame(2, -1, 0, 0, 1'b0);

        $display("[TB] missing hsync");
        err_count = 0;
        for (int i = 0; i < 2100; i++) send_pixel(1'b0, 1'b0, 0, 1'b0);
        checkOutput("sync_err_once", 32'(err_count), 1);
        checkOutput("sync_err_unlock", 32'(locked), 0);

        $display("[TB] reset mid-line and resume");
        applyReset();
        gen_frame(0, -1, 0, 7, 1'b0);
        gen_frame(2, -1, 0, 0, 1'b0);
        checkOutput("resume_line_len", 32'(line_len), 14);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
